// File: rtl/ucaspian_pkg.sv
// Shared sizes, FSM encoding and saturating add for the uCaspian dendrite stage.
package ucaspian_pkg;
    localparam int unsigned NEURONS = 256;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned ACC_W   = 16;

    typedef enum logic [2:0] {INIT, ACCUM, FLUSH, DRAIN, CLEAR} dend_state_e;

    // Clamp to the ACC_W range instead of wrapping; overflow shows as a sign/guard bit mismatch.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                                        input logic signed [7:0]       w8);
        logic signed [ACC_W:0] s;
        s = {acc[ACC_W-1], acc} + {{(ACC_W-7){w8[7]}}, w8};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction
endpackage

// File: rtl/ucaspian_dendrite_if.sv
// Fire input, drained-charge output and step/clear control of the dendrite stage.
interface ucaspian_dendrite_if;
    import ucaspian_pkg::*;

    logic                     enable;
    logic                     clear_act;
    logic                     clear_done;
    logic                     step_drain;
    logic                     drain_done;
    logic                     step_done;
    logic [ADDR_W-1:0]        dend_addr;
    logic signed [7:0]        dend_charge;
    logic                     dend_vld;
    logic                     dend_rdy;
    logic [ADDR_W-1:0]        neur_addr;
    logic signed [ACC_W-1:0]  neur_charge;
    logic                     neur_vld;
    logic                     neur_rdy;

    modport slave (
        input  enable, clear_act, step_drain, dend_addr, dend_charge, dend_vld, neur_rdy,
        output clear_done, drain_done, step_done, dend_rdy, neur_addr, neur_charge, neur_vld
    );

    modport master (
        output enable, clear_act, step_drain, dend_addr, dend_charge, dend_vld, neur_rdy,
        input  clear_done, drain_done, step_done, dend_rdy, neur_addr, neur_charge, neur_vld
    );
endinterface

// File: rtl/dp_ram_16x256.sv
// 16x256 simple dual-port RAM: one write port, one registered read port (read-old on collision).
module dp_ram_16x256 (
    input  logic        clk,
    input  logic        i_we,
    input  logic [7:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic        i_re,
    input  logic [7:0]  i_raddr,
    output logic [15:0] o_rdata
);
    logic [15:0] r_mem [0:255];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/ucaspian_dendrite.sv
// Dendritic accumulator: per-neuron saturating charge sums over a time step,
// drained in address order to the neuron stage on step_drain.
module ucaspian_dendrite
    import ucaspian_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    ucaspian_dendrite_if.slave bus
);
    dend_state_e r_state, w_next;
    logic [ADDR_W:0] r_ptr;

    logic                    r_s1_vld, r_s1_fwd, r_s2_vld;
    logic [ADDR_W-1:0]       r_s1_addr, r_s2_addr;
    logic signed [7:0]       r_s1_chg, r_s2_chg;
    logic signed [ACC_W-1:0] r_s1_fwd_data, r_s2_acc;
    logic signed [ACC_W-1:0] w_s2_sum, w_s1_acc, w_rdata, w_wdata;

    logic                    r_dv, r_neur_vld, r_drain_done, r_step_done;
    logic [ADDR_W-1:0]       r_daddr, r_neur_addr;
    logic signed [ACC_W-1:0] r_neur_charge;

    logic              w_rdy, w_accept, w_to_clear, w_ptr_done, w_s0_fwd;
    logic              w_hs, w_consume, w_issue, w_final, w_rd_zero;
    logic              w_we, w_re;
    logic [ADDR_W-1:0] w_waddr, w_raddr;

    dp_ram_16x256 u_ram (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(w_waddr),
        .i_wdata(w_wdata),
        .i_re   (w_re),
        .i_raddr(w_raddr),
        .o_rdata(w_rdata)
    );

    assign w_ptr_done = (r_ptr == (ADDR_W+1)'(NEURONS));
    assign w_rdy      = (r_state == ACCUM) && bus.enable && !bus.step_drain;
    assign w_accept   = bus.dend_vld && w_rdy;
    assign w_to_clear = bus.enable && bus.clear_act && (r_state != CLEAR);

    // A read issued while S2 writes the same entry returns stale data; S2 in turn beats that capture.
    assign w_s0_fwd = w_accept && w_we && (w_waddr == bus.dend_addr);
    assign w_s2_sum = sat_add(r_s2_acc, r_s2_chg);
    assign w_s1_acc = (r_s2_vld && (r_s2_addr == r_s1_addr)) ? w_s2_sum :
                      r_s1_fwd ? r_s1_fwd_data : w_rdata;

    // Drain scan: one read in flight (r_dv) feeding a single output holding register.
    assign w_hs      = r_neur_vld && bus.neur_rdy;
    assign w_rd_zero = (w_rdata == '0);
    assign w_consume = r_dv && (!r_neur_vld || w_hs);
    assign w_issue   = !w_ptr_done && (!r_dv || w_consume);
    assign w_final   = (r_state == DRAIN) && w_ptr_done && (!r_neur_vld || w_hs) && !(r_dv && !w_rd_zero);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        w_re    = 1'b0;
        w_raddr = '0;
        if (bus.enable) begin
            unique case (r_state)
                INIT, CLEAR: begin
                    w_we    = !w_ptr_done;
                    w_waddr = r_ptr[ADDR_W-1:0];
                end
                ACCUM, FLUSH: begin
                    w_we    = r_s2_vld;
                    w_waddr = r_s2_addr;
                    w_wdata = w_s2_sum;
                    w_re    = w_accept;
                    w_raddr = bus.dend_addr;
                end
                DRAIN: begin
                    w_we    = w_hs;
                    w_waddr = r_neur_addr;
                    w_re    = w_issue;
                    w_raddr = r_ptr[ADDR_W-1:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_to_clear) begin
            w_next = CLEAR;
        end else if (bus.enable) begin
            unique case (r_state)
                INIT:    if (w_ptr_done) w_next = ACCUM;
                ACCUM:   if (bus.step_drain) w_next = FLUSH;
                FLUSH:   if (!r_s1_vld && !r_s2_vld) w_next = DRAIN;
                DRAIN:   if (w_final) w_next = ACCUM;
                CLEAR:   if (w_ptr_done && !bus.clear_act) w_next = ACCUM;
                default: w_next = INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= INIT;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr         <= '0;
            r_s1_vld      <= 1'b0;
            r_s1_fwd      <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_chg      <= '0;
            r_s1_fwd_data <= '0;
            r_s2_vld      <= 1'b0;
            r_s2_addr     <= '0;
            r_s2_chg      <= '0;
            r_s2_acc      <= '0;
            r_dv          <= 1'b0;
            r_daddr       <= '0;
            r_neur_vld    <= 1'b0;
            r_neur_addr   <= '0;
            r_neur_charge <= '0;
            r_drain_done  <= 1'b0;
            r_step_done   <= 1'b0;
        end else begin
            r_drain_done <= 1'b0;
            r_step_done  <= (r_state == ACCUM) && !r_s1_vld && !r_s2_vld && !bus.dend_vld;
            if (w_to_clear) begin
                r_ptr      <= '0;
                r_s1_vld   <= 1'b0;
                r_s2_vld   <= 1'b0;
                r_dv       <= 1'b0;
                r_neur_vld <= 1'b0;
            end else if (bus.enable) begin
                r_s1_vld      <= w_accept;
                r_s1_addr     <= bus.dend_addr;
                r_s1_chg      <= bus.dend_charge;
                r_s1_fwd      <= w_s0_fwd;
                r_s1_fwd_data <= w_wdata;
                r_s2_vld      <= r_s1_vld;
                r_s2_addr     <= r_s1_addr;
                r_s2_chg      <= r_s1_chg;
                r_s2_acc      <= w_s1_acc;
                case (r_state)
                    INIT, CLEAR: if (!w_ptr_done) r_ptr <= r_ptr + 1'b1;
                    FLUSH: begin
                        r_ptr <= '0;
                        r_dv  <= 1'b0;
                    end
                    DRAIN: begin
                        if (w_issue) begin
                            r_ptr   <= r_ptr + 1'b1;
                            r_daddr <= r_ptr[ADDR_W-1:0];
                            r_dv    <= 1'b1;
                        end else if (w_consume) begin
                            r_dv <= 1'b0;
                        end
                        if (w_consume && !w_rd_zero) begin
                            r_neur_vld    <= 1'b1;
                            r_neur_addr   <= r_daddr;
                            r_neur_charge <= w_rdata;
                        end else if (w_hs) begin
                            r_neur_vld <= 1'b0;
                        end
                        r_drain_done <= w_final;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dend_rdy    = w_rdy;
    assign bus.clear_done  = (r_state == CLEAR) && w_ptr_done && bus.clear_act;
    assign bus.drain_done  = r_drain_done;
    assign bus.step_done   = r_step_done;
    assign bus.neur_vld    = r_neur_vld;
    assign bus.neur_addr   = r_neur_addr;
    assign bus.neur_charge = r_neur_charge;
endmodule

// File: tb/tb_ucaspian_dendrite.sv
// Randomized self-checking bench for ucaspian_dendrite against a per-neuron saturating-sum model.
module tb_ucaspian_dendrite;
    logic clk;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   model [256];

    ucaspian_dendrite_if bus();

    ucaspian_dendrite dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (bus.dend_rdy !== 1'b1 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic send_fire(input int a, input int c, input bit may_freeze);
        int t;
        bus.dend_addr   = 8'(a);
        bus.dend_charge = 8'(c);
        bus.dend_vld    = 1'b1;
        if (may_freeze && $urandom_range(0, 5) == 0) begin
            bus.enable = 1'b0;
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                #1;
                n_cmp++;
                if (bus.dend_rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL freeze_rdy: got %b, expected 0", bus.dend_rdy);
                end
            end
            bus.enable = 1'b1;
        end
        t = 0;
        #1;
        while (bus.dend_rdy !== 1'b1 && t < 400) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 400) begin
            n_cmp++;
            n_err++;
            $display("FAIL fire_accept: dend_rdy stuck %b, expected 1", bus.dend_rdy);
        end else begin
            model[a] = clamp16(model[a] + c);
        end
        @(negedge clk);
        bus.dend_vld = 1'b0;
    endtask

    task automatic do_drain(input string name, input int stall_max, input bit rnd, output int cycles);
        int  exp_a [$];
        int  exp_c [$];
        int  hold, need;
        bit  done, seen;
        for (int a = 0; a < 256; a++) begin
            if (model[a] != 0) begin
                exp_a.push_back(a);
                exp_c.push_back(model[a]);
                model[a] = 0;
            end
        end
        bus.neur_rdy   = 1'b1;
        bus.step_drain = 1'b1;
        @(negedge clk);
        bus.step_drain = 1'b0;
        done = 0; seen = 0; hold = 0; need = 0; cycles = 0;
        while (!done && cycles < 6000) begin
            if (bus.drain_done === 1'b1) begin
                done = 1;
            end else begin
                if (bus.neur_vld === 1'b1) begin
                    if (!seen) begin
                        seen = 1;
                        hold = 0;
                        need = rnd ? int'($urandom_range(0, stall_max)) : stall_max;
                    end
                    n_cmp++;
                    if (exp_a.size() == 0) begin
                        n_err++;
                        $display("FAIL %s extra_out: got addr=%0d charge=%0d, expected none",
                                 name, bus.neur_addr, bus.neur_charge);
                    end else if (bus.neur_addr !== 8'(exp_a[0]) || int'(bus.neur_charge) !== exp_c[0]) begin
                        n_err++;
                        $display("FAIL %s out: got addr=%0d charge=%0d, expected addr=%0d charge=%0d",
                                 name, bus.neur_addr, bus.neur_charge, exp_a[0], exp_c[0]);
                    end
                    if (hold < need) begin
                        bus.neur_rdy = 1'b0;
                        hold++;
                    end else begin
                        bus.neur_rdy = 1'b1;
                        seen = 0;
                        if (exp_a.size() > 0) begin
                            void'(exp_a.pop_front());
                            void'(exp_c.pop_front());
                        end
                    end
                end
                @(negedge clk);
                cycles++;
            end
        end
        bus.neur_rdy = 1'b1;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s drain_done: not seen within %0d cycles, expected pulse", name, cycles);
        end
        n_cmp++;
        if (exp_a.size() != 0) begin
            n_err++;
            $display("FAIL %s missing_out: %0d outputs missing, first addr=%0d, expected 0 missing",
                     name, exp_a.size(), exp_a[0]);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.drain_done !== 1'b0 || bus.dend_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL %s after_drain: got drain_done=%b dend_rdy=%b, expected 0/1",
                     name, bus.drain_done, bus.dend_rdy);
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.neur_vld !== 1'b0 || bus.neur_addr !== 8'd0 || bus.neur_charge !== 16'sd0) begin
            n_err++;
            $display("FAIL reset_neur: got vld=%b addr=%0d charge=%0d, expected 0/0/0",
                     bus.neur_vld, bus.neur_addr, bus.neur_charge);
        end
        n_cmp++;
        if (bus.drain_done !== 1'b0 || bus.clear_done !== 1'b0 || bus.step_done !== 1'b0 || bus.dend_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got drain=%b clear=%b step=%b rdy=%b, expected all 0",
                     bus.drain_done, bus.clear_done, bus.step_done, bus.dend_rdy);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.dend_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL init_rdy: got %b, expected 0 during INIT", bus.dend_rdy);
        end
        wait_ready(n);
        n_cmp++;
        if (n < 250 || n > 260) begin
            n_err++;
            $display("FAIL init_len: got %0d cycles to ready, expected about 256", n);
        end
        @(negedge clk);
    endtask

    task automatic test_empty_drain();
        int cyc;
        do_drain("empty", 0, 0, cyc);
        n_cmp++;
        if (cyc < 256 || cyc > 264) begin
            n_err++;
            $display("FAIL empty_scan_len: got %0d cycles, expected 256..264", cyc);
        end
    endtask

    task automatic test_same_addr();
        int cyc;
        send_fire(5, 3, 0);
        send_fire(5, 4, 0);
        send_fire(5, -2, 0);
        n_cmp++;
        if (model[5] !== 5) begin
            n_err++;
            $display("FAIL same_addr_model: got %0d, expected 5", model[5]);
        end
        do_drain("same_addr", 0, 0, cyc);
    endtask

    task automatic test_saturation();
        int cyc;
        for (int i = 0; i < 300; i++) send_fire(9, 127, 0);
        for (int i = 0; i < 300; i++) send_fire(10, -128, 0);
        n_cmp++;
        if (model[9] !== 32767 || model[10] !== -32768) begin
            n_err++;
            $display("FAIL sat_model: got %0d/%0d, expected 32767/-32768", model[9], model[10]);
        end
        do_drain("saturation", 0, 0, cyc);
    endtask

    task automatic test_order_stall();
        int cyc;
        send_fire(255, int'($urandom_range(1, 127)), 0);
        send_fire(0, -int'($urandom_range(1, 128)), 0);
        send_fire(128, int'($urandom_range(1, 127)), 0);
        do_drain("order_stall", 10, 0, cyc);
        do_drain("second_drain", 0, 0, cyc);
    endtask

    task automatic test_clear_mid_drain();
        int t, n;
        send_fire(3, 20, 0);
        send_fire(4, -7, 0);
        send_fire(7, 1, 0);
        for (int a = 0; a < 256; a++) model[a] = 0;
        bus.neur_rdy   = 1'b1;
        bus.step_drain = 1'b1;
        @(negedge clk);
        bus.step_drain = 1'b0;
        t = 0;
        while (bus.neur_vld !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.neur_vld !== 1'b1 || bus.neur_addr !== 8'd3 || bus.neur_charge !== 16'sd20) begin
            n_err++;
            $display("FAIL clr_first_out: got vld=%b addr=%0d charge=%0d, expected 1/3/20",
                     bus.neur_vld, bus.neur_addr, bus.neur_charge);
        end
        @(negedge clk);
        bus.neur_rdy = 1'b0;
        t = 0;
        while (bus.neur_vld !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (bus.neur_vld !== 1'b1 || bus.neur_addr !== 8'd4 || bus.neur_charge !== -16'sd7) begin
            n_err++;
            $display("FAIL clr_second_out: got vld=%b addr=%0d charge=%0d, expected 1/4/-7",
                     bus.neur_vld, bus.neur_addr, bus.neur_charge);
        end
        bus.clear_act = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.neur_vld !== 1'b0) begin
            n_err++;
            $display("FAIL clr_vld_drop: got %b, expected 0", bus.neur_vld);
        end
        n = 1;
        while (bus.clear_done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n < 256 || n > 260) begin
            n_err++;
            $display("FAIL clr_len: got %0d cycles to clear_done, expected 256..260", n);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.clear_done !== 1'b1 || bus.dend_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL clr_hold: got clear_done=%b rdy=%b, expected 1/0", bus.clear_done, bus.dend_rdy);
        end
        bus.clear_act = 1'b0;
        bus.neur_rdy  = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (bus.clear_done !== 1'b0 || bus.dend_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL clr_exit: got clear_done=%b rdy=%b, expected 0/1", bus.clear_done, bus.dend_rdy);
        end
        do_drain("after_clear", 0, 0, t);
    endtask

    task automatic test_async_reset();
        int n, cyc;
        send_fire(20, 50, 0);
        send_fire(20, 60, 0);
        bus.dend_addr   = 8'd21;
        bus.dend_charge = 8'sd5;
        bus.dend_vld    = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.dend_rdy !== 1'b0 || bus.neur_vld !== 1'b0 || bus.step_done !== 1'b0 ||
            bus.drain_done !== 1'b0 || bus.clear_done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got rdy=%b vld=%b step=%b drain=%b clear=%b, expected all 0",
                     bus.dend_rdy, bus.neur_vld, bus.step_done, bus.drain_done, bus.clear_done);
        end
        bus.dend_vld = 1'b0;
        for (int a = 0; a < 256; a++) model[a] = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(n);
        n_cmp++;
        if (n < 250 || n > 260) begin
            n_err++;
            $display("FAIL async_init_len: got %0d cycles, expected about 256", n);
        end
        @(negedge clk);
        send_fire(20, -9, 0);
        send_fire(21, 4, 0);
        send_fire(20, 2, 0);
        do_drain("post_reset", 0, 0, cyc);
    endtask

    task automatic test_random(input int rounds);
        int a, c, cyc;
        for (int r = 0; r < rounds; r++) begin
            for (int i = 0; i < 120; i++) begin
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
                c = int'($urandom_range(0, 255)) - 128;
                send_fire(a, c, 1);
                if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            do_drain("random", 3, 1, cyc);
        end
    endtask

    task automatic test_step_done();
        int cyc;
        send_fire(40, 11, 0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (bus.step_done !== 1'b1) begin
            n_err++;
            $display("FAIL step_done_idle: got %b, expected 1", bus.step_done);
        end
        bus.enable   = 1'b0;
        bus.dend_vld = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.step_done !== 1'b0) begin
            n_err++;
            $display("FAIL step_done_vld: got %b, expected 0", bus.step_done);
        end
        bus.dend_vld = 1'b0;
        bus.enable   = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bus.step_done !== 1'b1) begin
            n_err++;
            $display("FAIL step_done_back: got %b, expected 1", bus.step_done);
        end
        do_drain("step_done", 0, 0, cyc);
    endtask

    initial begin
        reset          = 1'b0;
        bus.enable     = 1'b1;
        bus.clear_act  = 1'b0;
        bus.step_drain = 1'b0;
        bus.dend_addr  = '0;
        bus.dend_charge = '0;
        bus.dend_vld   = 1'b0;
        bus.neur_rdy   = 1'b1;
        for (int a = 0; a < 256; a++) model[a] = 0;

        test_reset();
        test_empty_drain();
        test_same_addr();
        test_saturation();
        test_order_stall();
        test_clear_mid_drain();
        test_async_reset();
        test_random(2);
        test_step_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
